// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: loads a WIDTH-bit word and presents one bit per
// Shift_EN beat, LSB or MSB first, with back-to-back reload on the last-bit cycle.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             Load,
    input  logic             Shift_EN,
    output logic             Ready,
    output logic             Serial_OUT,
    output logic             Serial_Valid,
    output logic             Busy,
    output logic             Done,
    output logic             o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_load;
    logic             w_out_bit;

    // Handshakes: a word transfers on an edge where Load && Ready; a bit transfers
    // on an edge where Serial_Valid && Shift_EN. Ready also opens on the last-bit
    // beat so a new word can follow the old one with no gap.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_last      = (r_state == SHIFT) && (r_cnt == CW'(1)) && Shift_EN;
        Ready       = (r_state == IDLE) || w_last;
        w_load      = Load && Ready;
        w_done_nxt  = w_last;

        if (w_load) begin
            w_shreg_nxt = IN;
            w_cnt_nxt   = CW'(WIDTH);
            w_state_nxt = SHIFT;
        end else if ((r_state == SHIFT) && Shift_EN) begin
            if (LSB_FIRST) begin
                w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
            end else begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
            end
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_out_bit    = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
    assign Serial_Valid = (r_state == SHIFT);
    assign Busy         = Serial_Valid;
    assign Serial_OUT   = Serial_Valid & w_out_bit;
    assign Done         = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=4 in both bit orders sharing one stimulus,
// with hand-computed expectations per cycle.
module tb_piso_serializer;
    logic       clk;
    logic       rst;
    logic [3:0] in_w;
    logic       load;
    logic       shift_en;

    logic l_ready, l_out, l_valid, l_busy, l_done, l_dbg;
    logic m_ready, m_out, m_valid, m_busy, m_done, m_dbg;

    int n_vec;
    int n_err;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(clk), .RST(rst), .IN(in_w), .Load(load), .Shift_EN(shift_en),
        .Ready(l_ready), .Serial_OUT(l_out), .Serial_Valid(l_valid),
        .Busy(l_busy), .Done(l_done), .o_dbg_state(l_dbg)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .CLK(clk), .RST(rst), .IN(in_w), .Load(load), .Shift_EN(shift_en),
        .Ready(m_ready), .Serial_OUT(m_out), .Serial_Valid(m_valid),
        .Busy(m_busy), .Done(m_done), .o_dbg_state(m_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one comparison
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LSB-first instance, packed as {out, valid, busy, ready, done}
    task automatic chk_l(input string tag, input logic [4:0] exp);
        chk(tag, {3'b000, l_out, l_valid, l_busy, l_ready, l_done}, {3'b000, exp});
    endtask

    task automatic chk_m(input string tag, input logic [4:0] exp);
        chk(tag, {3'b000, m_out, m_valid, m_busy, m_ready, m_done}, {3'b000, exp});
    endtask

    // drive inputs just after a rising edge, then move to the falling edge to sample
    task automatic step(input logic ld, input logic [3:0] din, input logic se);
        @(posedge clk);
        #1;
        load     = ld;
        in_w     = din;
        shift_en = se;
        @(negedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        load     = 1'b0;
        in_w     = 4'h0;
        shift_en = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_l("reset_lsb", 5'b00010);
        chk_m("reset_msb", 5'b00010);
        chk("reset_dbg", {6'd0, l_dbg, m_dbg}, 8'd0);

        // basic word 1011, Load on the first edge after reset release
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b1;
        in_w = 4'b1011;
        @(negedge clk);
        chk_l("s1_ready_after_rst", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("s1_lsb_b0", 5'b11100);
        chk_m("s1_msb_b0", 5'b11100);
        chk("s1_dbg_shift", {7'd0, l_dbg}, 8'd1);
        step(1'b0, 4'h0, 1'b1);
        chk_l("s1_lsb_b1", 5'b11100);
        chk_m("s1_msb_b1", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("s1_lsb_b2", 5'b01100);
        chk_m("s1_msb_b2", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("s1_lsb_b3", 5'b11110);
        chk_m("s1_msb_b3", 5'b11110);
        step(1'b0, 4'h0, 1'b0);
        chk_l("s1_lsb_done", 5'b00011);
        chk_m("s1_msb_done", 5'b00011);
        step(1'b0, 4'h0, 1'b0);
        chk_l("s1_done_once", 5'b00010);

        // Shift_EN in IDLE does nothing
        step(1'b0, 4'h0, 1'b1);
        chk_l("idle_shift_a", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("idle_shift_b", 5'b00010);

        // stall: 0110, one beat then three held cycles
        step(1'b1, 4'b0110, 1'b0);
        chk_l("st_ready", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("st_b0", 5'b01100);
        step(1'b0, 4'h0, 1'b0);
        chk_l("st_hold1", 5'b11100);
        step(1'b0, 4'h0, 1'b0);
        chk_l("st_hold2", 5'b11100);
        step(1'b0, 4'h0, 1'b0);
        chk_l("st_hold3", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("st_b1", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("st_b2", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("st_b3", 5'b01110);
        step(1'b0, 4'h0, 1'b0);
        chk_l("st_done", 5'b00011);

        // back-to-back A then 5
        step(1'b1, 4'hA, 1'b0);
        chk_l("bb_ready", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b0", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b1", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b2", 5'b01100);
        step(1'b1, 4'h5, 1'b1);
        chk_l("bb_b3_reload", 5'b11110);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b4_done", 5'b11101);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b5", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b6", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("bb_b7", 5'b01110);
        step(1'b0, 4'h0, 1'b0);
        chk_l("bb_done2", 5'b00011);

        // Load while busy is ignored: 3 with F offered during bit 1
        step(1'b1, 4'h3, 1'b0);
        chk_l("lb_ready", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("lb_b0", 5'b11100);
        step(1'b1, 4'hF, 1'b1);
        chk_l("lb_b1", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("lb_b2", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("lb_b3", 5'b01110);
        step(1'b0, 4'h0, 1'b0);
        chk_l("lb_done", 5'b00011);

        // reset mid-word: E (bits 0,1,1,1), reset between edges during bit 1
        step(1'b1, 4'hE, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        chk_l("rm_b0", 5'b01100);
        step(1'b0, 4'h0, 1'b0);
        chk_l("rm_b1", 5'b11100);
        #1 rst = 1'b1;
        #1;
        chk_l("rm_async", 5'b00010);
        chk_m("rm_async_msb", 5'b00010);
        @(posedge clk);
        #1;
        chk_l("rm_no_done", 5'b00010);
        rst  = 1'b0;
        load = 1'b1;
        in_w = 4'h9;
        @(negedge clk);
        chk_l("rm_ready", 5'b00010);
        step(1'b0, 4'h0, 1'b1);
        chk_l("rm9_b0", 5'b11100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("rm9_b1", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("rm9_b2", 5'b01100);
        step(1'b0, 4'h0, 1'b1);
        chk_l("rm9_b3", 5'b11110);
        step(1'b0, 4'h0, 1'b0);
        chk_l("rm9_done", 5'b00011);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: parallel word width in bits; legal range 2..64.
REQ-002 SHALL provide parameter LSB_FIRST, default 1: 1 shifts out bit 0 first; 0 shifts out bit WIDTH-1 first.
REQ-003 SHALL provide port CLK  input  1  rising-edge clock for all state.
REQ-004 SHALL provide port RST  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port IN  input  WIDTH  parallel data word.
REQ-006 SHALL provide port Load  input  1  load request; accepted only on a cycle where Ready=1.
REQ-007 SHALL provide port Shift_EN  input  1  serial-side advance; consumes the current bit when Serial_Valid=1.
REQ-008 SHALL provide port Ready  output  1  combinational; block can accept Load this cycle.
REQ-009 SHALL provide port Serial_OUT  output  1  current serial bit.
REQ-010 SHALL provide port Serial_Valid  output  1  Serial_OUT holds a valid data bit.
REQ-011 SHALL provide port Busy  output  1  word in progress; equals Serial_Valid.
REQ-012 SHALL provide port Done  output  1  one-cycle pulse after the last bit of a word is consumed.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SHIFT, with a WIDTH-bit shift register and a bit counter of width clog2(WIDTH+1).
REQ-014 SHALL drive Ready=1 in IDLE, and in SHIFT only when the counter is 1 and Shift_EN=1 (last-bit consume cycle); Ready SHALL be 0 otherwise.
REQ-015 SHALL, on a rising edge with Load=1 and Ready=1, capture IN into the shift register, set the counter to WIDTH and enter SHIFT.
REQ-016 SHALL present the first bit on Serial_OUT, with Serial_Valid=1, in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-017 SHALL drive Serial_OUT from register bit 0 when LSB_FIRST=1, and from bit WIDTH-1 when LSB_FIRST=0.
REQ-018 SHALL, in SHIFT with Shift_EN=1, shift the register one position toward the output bit, fill the vacated end with 0, and decrement the counter.
REQ-019 SHALL, in SHIFT with Shift_EN=0, hold the register, counter, Serial_OUT and Serial_Valid unchanged for any number of cycles.
REQ-020 SHALL return to IDLE when the counter is 1, Shift_EN=1 and Load=0.
REQ-021 SHALL, when the counter is 1, Shift_EN=1 and Load=1, reload IN and remain in SHIFT (back-to-back), so the first bit of the new word follows the last bit of the old word with no gap.
REQ-022 SHALL assert Done for exactly one cycle, the cycle after the last-bit consume edge, including the back-to-back case.
REQ-023 SHALL ignore Load while Ready=0, with no change to register, counter or outputs.
REQ-024 SHALL ignore Shift_EN in IDLE.
REQ-025 SHALL drive Serial_OUT=0 whenever Serial_Valid=0.

Reset
REQ-026 SHALL, while RST=1 and independent of CLK, force IDLE, shift register=0, counter=0, Serial_OUT=0, Serial_Valid=0, Busy=0 and Done=0.
REQ-027 SHALL, when reset is asserted mid-word, discard the remaining bits; no Done pulse SHALL follow.
REQ-028 SHALL accept Load on the first rising edge after RST deasserts, with Ready=1 in that cycle.

Verification
REQ-029 SHALL cover this scenario (WIDTH=4, LSB_FIRST=1): Load with IN=4'b1011, then Shift_EN=1 continuously -> Serial_OUT=1,1,0,1 over 4 cycles with Serial_Valid=1; Done=1 in cycle 5; Ready=1 afterwards.
REQ-030 SHALL cover this scenario (WIDTH=4, LSB_FIRST=0): Load with IN=4'b1011, Shift_EN=1 -> Serial_OUT=1,0,1,1.
REQ-031 SHALL cover this stall scenario: load 4'b0110, Shift_EN=1 for one cycle, then 0 for 3 cycles -> second bit (1) held stable 3 cycles with Serial_Valid=1 and Ready=0; sequence completes on resume.
REQ-032 SHALL cover this back-to-back scenario: words 4'hA then 4'h5, second Load asserted in the last-bit cycle -> 8 contiguous valid bits 0,1,0,1,1,0,1,0; Done pulses after bit 4 and after bit 8.
REQ-033 SHALL cover this Load-while-busy scenario: Load with 4'hF during the second bit of 4'h3 -> ignored; output 1,1,0,0 unchanged.
REQ-034 SHALL cover this reset mid-word scenario: assert RST between CLK edges during bit 2 -> outputs 0 immediately with no Done; after release, Load 4'h9 -> 1,0,0,1.
